line_ctrl: RTL and testbench
============================

Name: line_ctrl

Overview:
- Sequences the tokenizer. Assembles UART receive bytes into a fixed-length line buffer, with backspace editing.
- On end-of-line, offers the completed line to the tokenizer via a level handshake.
- Holds off further UART input until the tokenizer has fully drained the line.
- Sits between the UART RX path and the tokenizer input port (line array, length, ready).

Parameters:
- LENGTH, 16: line buffer slots; matches tokenizer LENGTH.
- EOL, "\n": line terminator; stored in the buffer and counted in the length.
- BS, 8'h08: backspace code; 8'h7F (DEL) is treated identically.
- LEN_BITS, $clog2(LENGTH): width of the length fields. Maximum stored length is LENGTH-1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  clock enable; when low, all state and outputs hold.
- i_rx_data  in  8  received UART byte.
- i_rx_valid  in  1  single-cycle strobe qualifying i_rx_data.
- o_rx_ready  out  1  high when a byte will be accepted this cycle.
- o_line  out  8 x LENGTH  line buffer contents, to tokenizer i_line.
- o_len  out  LEN_BITS  stored length including EOL, to tokenizer i_len.
- o_ready  out  1  line offered, to tokenizer i_ready.
- i_tok_busy  in  1  tokenizer o_data_ready; high while the tokenizer owns the line.
- o_overflow  out  1  sticky flag: a printable byte was dropped because the buffer was full.
- d_state  out  2  current FSM state, for debug.

Behaviour:
- Reset (sync, i_rst=1 at posedge): state=FILL, all o_line slots=0, o_len=0, o_ready=0, o_overflow=0, o_rx_ready=1. Reset overrides i_en and aborts any state, including OFFER and DRAIN.
- o_rx_ready = (state==FILL) & i_en. Combinational, no latency.
- A byte is accepted when i_rx_valid & o_rx_ready at the posedge. Bytes strobed while o_rx_ready=0 are discarded silently.
- FILL state, per accepted byte:
  - BS or DEL: if o_len>0, decrement o_len and write 0 to slot o_len-1; if o_len==0, no effect.
  - CR (8'h0D): ignored.
  - EOL: write EOL to slot o_len, increment o_len, next state OFFER. Always accepted, because the printable limit reserves one slot for EOL.
  - Any other byte: if o_len < LENGTH-2, write to slot o_len and increment o_len. Otherwise drop the byte and set o_overflow=1.
- OFFER state: o_ready=1. On the first cycle with i_tok_busy=1: o_ready<=0, next state DRAIN. o_ready rises the cycle after the EOL is accepted.
- DRAIN state: wait for i_tok_busy=0. Then clear all slots to 0, o_len<=0, o_overflow<=0, next state FILL. o_rx_ready is reasserted the following cycle.
- i_tok_busy already high on OFFER entry (stale line from the tokenizer): treated as acceptance; go to DRAIN. This matches the tokenizer's level semantics.
- o_line and o_len are stable throughout OFFER and DRAIN.
- Empty line (EOL only): o_len=1, offered normally.
- State encoding: FILL=0, OFFER=1, DRAIN=2. Code 3 is illegal and recovers to FILL with the buffer cleared.
- Arithmetic: all length math is unsigned, LEN_BITS wide. Underflow is impossible (guarded); overflow is impossible (guarded).

Optional Feature:
- Macro: LINE_CTRL_ECHO_EN.
- When defined, adds ports o_tx_data (8 bits) and o_tx_valid (1 bit). These register the echo one cycle after acceptance, as a single-cycle pulse:
  - an accepted printable byte echoes itself;
  - an effective backspace echoes the 3-pulse sequence BS, " ", BS on consecutive cycles, and o_rx_ready is held low for those 2 extra cycles;
  - EOL echoes "\r" then "\n";
  - dropped or ignored bytes produce no echo.
- When not defined: no tx ports exist and no echo logic is built.

Decomposition:
- Shared package forth_pkg holds:
  - WIDTH=8;
  - character constants CHAR_EOL, CHAR_BS, CHAR_DEL, CHAR_CR, CHAR_SP;
  - line_ctrl_state_t enum {FILL, OFFER, DRAIN}.
- One natural sub-module, line_buf: LENGTH x 8 register array with a write port (addr, data, we) and a clear-all input. line_ctrl keeps the FSM, length counter and echo logic.

Test Plan:
- Accept "DUP\n" (4 strobes): o_len=4, o_line[0..3]="D","U","P",8'h0A; o_ready=1 the cycle after EOL. Raise i_tok_busy: o_ready=0 next cycle. Drop it: o_len=0, o_rx_ready=1.
- Accept "AB", BS, "C\n": o_line[0..2]="A","C",8'h0A, o_len=3. Also send BS with o_len=0: no change.
- Send 20 printable bytes, then "\n": o_len=15, slots 0..13 hold the first 14 bytes, slot 14=8'h0A, o_overflow=1. o_overflow clears after DRAIN.
- Strobe bytes during OFFER/DRAIN: o_rx_ready=0 and the buffer is unchanged. Pulse i_rst during DRAIN: next cycle state=FILL, o_len=0, o_ready=0.
- Hold i_en=0 for 5 cycles while strobing i_rx_valid: no state change, no byte stored. Resume: normal acceptance.
- With LINE_CTRL_ECHO_EN: send "X", BS → o_tx_valid pulses with "X", then 8'h08, 8'h20, 8'h08. o_rx_ready stays low for 2 cycles after the BS.

Source files
------------

// File: rtl/forth_pkg.sv
// Shared definitions for the line controller and its neighbours.
//   WIDTH              : character width in bits
//   CHAR_*             : control characters recognised by the line editor
//   line_ctrl_state_t  : line controller FSM encoding (code 3 is illegal)
package forth_pkg;

  localparam int WIDTH = 8;

  localparam logic [WIDTH-1:0] CHAR_EOL = 8'h0A;
  localparam logic [WIDTH-1:0] CHAR_BS  = 8'h08;
  localparam logic [WIDTH-1:0] CHAR_DEL = 8'h7F;
  localparam logic [WIDTH-1:0] CHAR_CR  = 8'h0D;
  localparam logic [WIDTH-1:0] CHAR_SP  = 8'h20;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    OFFER = 2'd1,
    DRAIN = 2'd2
  } line_ctrl_state_t;

endpackage

// File: rtl/line_buf.sv
// Line buffer: LENGTH slots of WIDTH bits.
//   i_clk  : clock
//   i_clr  : synchronous clear of every slot (priority over write)
//   i_we   : write enable for slot i_addr
//   i_addr : slot index
//   i_data : write data
//   o_line : all slots flattened, slot k at bits [k*WIDTH +: WIDTH]
module line_buf
  import forth_pkg::*;
#(
  parameter int LENGTH   = 16,
  parameter int LEN_BITS = $clog2(LENGTH)
) (
  input  logic                      i_clk,
  input  logic                      i_clr,
  input  logic                      i_we,
  input  logic [LEN_BITS-1:0]       i_addr,
  input  logic [WIDTH-1:0]          i_data,
  output logic [WIDTH*LENGTH-1:0]   o_line
);

  logic [WIDTH-1:0] slot_q [LENGTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int k = 0; k < LENGTH; k++) slot_q[k] <= '0;
    end else if (i_we) begin
      slot_q[i_addr] <= i_data;
    end
  end

  for (genvar g = 0; g < LENGTH; g++) begin : g_out
    assign o_line[g*WIDTH +: WIDTH] = slot_q[g];
  end

endmodule

// File: rtl/line_ctrl.sv
// Line controller: assembles UART RX bytes into a line with backspace
// editing, offers the finished line to the tokenizer with a level
// handshake, and blocks further input until the tokenizer has drained it.
//
// Ports:
//   i_clk, i_rst (sync, active high), i_en (clock enable)
//   i_rx_data/i_rx_valid/o_rx_ready : UART receive side
//   o_line/o_len/o_ready            : line offered to the tokenizer
//   i_tok_busy                      : tokenizer owns the line
//   o_overflow                      : sticky, a printable byte was dropped
//   d_state                         : FSM state for debug
//   o_tx_data/o_tx_valid            : echo stream (only with LINE_CTRL_ECHO_EN)
//
// Build option: define LINE_CTRL_ECHO_EN to add the echo output.
//
// state | meaning
// FILL  | accepting bytes into the buffer
// OFFER | line complete, o_ready high, waiting for tokenizer to go busy
// DRAIN | tokenizer owns the line, waiting for it to release
module line_ctrl
  import forth_pkg::*;
#(
  parameter int               LENGTH   = 16,
  parameter logic [WIDTH-1:0] EOL      = CHAR_EOL,
  parameter logic [WIDTH-1:0] BS       = CHAR_BS,
  parameter int               LEN_BITS = $clog2(LENGTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [WIDTH-1:0]        i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic [WIDTH*LENGTH-1:0] o_line,
  output logic [LEN_BITS-1:0]     o_len,
  output logic                    o_ready,
  input  logic                    i_tok_busy,
  output logic                    o_overflow,
`ifdef LINE_CTRL_ECHO_EN
  output logic [WIDTH-1:0]        o_tx_data,
  output logic                    o_tx_valid,
`endif
  output logic [1:0]              d_state
);

  localparam logic [LEN_BITS-1:0] ONE = LEN_BITS'(1);
  // Printables stop two short of LENGTH so one slot always remains for EOL.
  localparam logic [LEN_BITS-1:0] PRINT_LIM = LEN_BITS'(LENGTH - 2);

  line_ctrl_state_t    state_q;
  logic [LEN_BITS-1:0] len_q;
  logic                ready_q;
  logic                ovf_q;
  logic                echo_busy;

  logic                buf_clr;
  logic                buf_we;
  logic [LEN_BITS-1:0] buf_addr;
  logic [WIDTH-1:0]    buf_data;

`ifdef LINE_CTRL_ECHO_EN
  // Echo sequences longer than one byte queue their tail here.
  logic [WIDTH-1:0] tx_data_q;
  logic             tx_valid_q;
  logic [WIDTH-1:0] pend0_q;
  logic [WIDTH-1:0] pend1_q;
  logic [1:0]       pend_cnt_q;

  assign echo_busy  = (pend_cnt_q != 2'd0);
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
`else
  assign echo_busy = 1'b0;
`endif

  logic accept, is_bs, is_eol, is_cr;

  assign o_rx_ready = (state_q == FILL) & i_en & ~echo_busy;
  assign accept     = i_rx_valid & o_rx_ready;
  assign is_bs      = (i_rx_data == BS) | (i_rx_data == CHAR_DEL);
  assign is_eol     = (i_rx_data == EOL);
  assign is_cr      = (i_rx_data == CHAR_CR);

  // Buffer write port decode, mirrors the length updates in the FSM below.
  always_comb begin
    buf_clr  = i_rst;
    buf_we   = 1'b0;
    buf_addr = len_q;
    buf_data = i_rx_data;
    if (!i_rst && i_en) begin
      case (state_q)
        FILL: begin
          if (accept) begin
            if (is_eol) begin
              buf_we = 1'b1;
            end else if (is_bs) begin
              if (len_q != '0) begin
                buf_we   = 1'b1;
                buf_addr = len_q - ONE;
                buf_data = '0;
              end
            end else if (!is_cr && (len_q < PRINT_LIM)) begin
              buf_we = 1'b1;
            end
          end
        end
        OFFER: ;
        DRAIN:   buf_clr = ~i_tok_busy;
        default: buf_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= FILL;
      len_q   <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef LINE_CTRL_ECHO_EN
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      pend0_q    <= '0;
      pend1_q    <= '0;
      pend_cnt_q <= 2'd0;
`endif
    end else if (i_en) begin
`ifdef LINE_CTRL_ECHO_EN
      // Drain the echo queue; a new acceptance below overrides this
      // (acceptance only happens when the queue is empty).
      if (pend_cnt_q != 2'd0) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= pend0_q;
        pend0_q    <= pend1_q;
        pend_cnt_q <= pend_cnt_q - 2'd1;
      end else begin
        tx_valid_q <= 1'b0;
      end
`endif
      case (state_q)
        FILL: begin
          if (accept) begin
            if (is_eol) begin
              len_q   <= len_q + ONE;
              ready_q <= 1'b1;
              state_q <= OFFER;
`ifdef LINE_CTRL_ECHO_EN
              tx_valid_q <= 1'b1;
              tx_data_q  <= CHAR_CR;
              pend0_q    <= EOL;
              pend_cnt_q <= 2'd1;
`endif
            end else if (is_bs) begin
              if (len_q != '0) begin
                len_q <= len_q - ONE;
`ifdef LINE_CTRL_ECHO_EN
                tx_valid_q <= 1'b1;
                tx_data_q  <= CHAR_BS;
                pend0_q    <= CHAR_SP;
                pend1_q    <= CHAR_BS;
                pend_cnt_q <= 2'd2;
`endif
              end
            end else if (!is_cr) begin
              if (len_q < PRINT_LIM) begin
                len_q <= len_q + ONE;
`ifdef LINE_CTRL_ECHO_EN
                tx_valid_q <= 1'b1;
                tx_data_q  <= i_rx_data;
`endif
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
        end
        OFFER: begin
          // Busy already high on entry is a stale line; still counts as taken.
          if (i_tok_busy) begin
            ready_q <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!i_tok_busy) begin
            len_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= FILL;
          end
        end
        default: begin
          len_q   <= '0;
          ovf_q   <= 1'b0;
          ready_q <= 1'b0;
          state_q <= FILL;
        end
      endcase
    end
  end

  line_buf #(
    .LENGTH   (LENGTH),
    .LEN_BITS (LEN_BITS)
  ) u_buf (
    .i_clk  (i_clk),
    .i_clr  (buf_clr),
    .i_we   (buf_we),
    .i_addr (buf_addr),
    .i_data (buf_data),
    .o_line (o_line)
  );

  assign o_len      = len_q;
  assign o_ready    = ready_q;
  assign o_overflow = ovf_q;
  assign d_state    = state_q;

endmodule

// File: tb/tb_line_ctrl.sv
// Bench for line_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a byte-array model of the line editor.
module tb_line_ctrl;
  import forth_pkg::*;

  localparam int LENGTH = 16;
  localparam int LB     = 4;
`ifdef LINE_CTRL_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic                  i_clk = 1'b0;
  logic                  i_rst = 1'b0;
  logic                  i_en = 1'b0;
  logic                  i_rx_valid = 1'b0;
  logic                  i_tok_busy = 1'b0;
  logic [7:0]            i_rx_data = 8'h00;
  logic                  o_rx_ready, o_ready, o_overflow;
  logic [8*LENGTH-1:0]   o_line;
  logic [LB-1:0]         o_len;
  logic [1:0]            d_state;
`ifdef LINE_CTRL_ECHO_EN
  logic [7:0]            o_tx_data;
  logic                  o_tx_valid;
`endif

  always #5 i_clk = ~i_clk;

  line_ctrl #(.LENGTH(LENGTH)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_line     (o_line),
    .o_len      (o_len),
    .o_ready    (o_ready),
    .i_tok_busy (i_tok_busy),
    .o_overflow (o_overflow),
`ifdef LINE_CTRL_ECHO_EN
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
`endif
    .d_state    (d_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the line is a plain byte array plus a count.
  int          m_state;   // 0 filling, 1 offered, 2 owned by tokenizer
  int          m_len;
  bit          m_ready, m_ovf;
  byte unsigned m_buf [LENGTH];
  byte unsigned m_txq [$];
  bit          m_txv;
  byte unsigned m_txd;

  function automatic logic [127:0] m_line();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < LENGTH; k++) v[k*8 +: 8] = m_buf[k];
    return v;
  endfunction

  function automatic bit m_rxr(input bit en);
    return (m_state == 0) && en && (m_txq.size() == 0);
  endfunction

  task automatic m_reset();
    m_state = 0; m_len = 0; m_ready = 0; m_ovf = 0;
    for (int k = 0; k < LENGTH; k++) m_buf[k] = 8'h00;
    m_txq.delete();
    m_txv = 0; m_txd = 8'h00;
  endtask

  task automatic m_edge(input bit rst, input bit en, input bit valid,
                        input byte unsigned data, input bit busy);
    bit acc;
    if (rst) begin m_reset(); return; end
    if (!en) return;
    acc = valid && m_rxr(1'b1);
    case (m_state)
      0: if (acc) begin
        if (data == 8'h0A) begin
          m_buf[m_len] = 8'h0A; m_len++; m_ready = 1; m_state = 1;
          if (ECHO) begin m_txq.push_back(8'h0D); m_txq.push_back(8'h0A); end
        end else if (data == 8'h08 || data == 8'h7F) begin
          if (m_len > 0) begin
            m_len--; m_buf[m_len] = 8'h00;
            if (ECHO) begin m_txq.push_back(8'h08); m_txq.push_back(8'h20); m_txq.push_back(8'h08); end
          end
        end else if (data == 8'h0D) begin
        end else if (m_len < LENGTH - 2) begin
          m_buf[m_len] = data; m_len++;
          if (ECHO) m_txq.push_back(data);
        end else begin
          m_ovf = 1;
        end
      end
      1: if (busy) begin m_ready = 0; m_state = 2; end
      default: if (!busy) begin
        for (int k = 0; k < LENGTH; k++) m_buf[k] = 8'h00;
        m_len = 0; m_ovf = 0; m_state = 0;
      end
    endcase
    if (m_txq.size() > 0) begin m_txv = 1; m_txd = m_txq.pop_front(); end
    else m_txv = 0;
  endtask

  // One clock: drive at negedge, check ready before the edge, outputs after.
  task automatic cyc(input bit rst, input bit en, input bit valid,
                     input byte unsigned data, input bit busy);
    i_rst = rst; i_en = en; i_rx_valid = valid; i_rx_data = data; i_tok_busy = busy;
    #1;
    chk("rx_ready", o_rx_ready, m_rxr(en));
    @(posedge i_clk);
    m_edge(rst, en, valid, data, busy);
    @(negedge i_clk);
    chk("len", o_len, m_len[LB-1:0]);
    chk("ready", o_ready, m_ready);
    chk("overflow", o_overflow, m_ovf);
    chk("state", d_state, m_state[1:0]);
    chk("line", o_line, m_line());
`ifdef LINE_CTRL_ECHO_EN
    chk("tx_valid", o_tx_valid, m_txv);
    if (m_txv) chk("tx_data", o_tx_data, m_txd);
`endif
  endtask

  task automatic send(input byte unsigned b);
    cyc(1'b0, 1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic idle(input bit busy);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, busy);
  endtask

  task automatic drain();
    idle(1'b1); idle(1'b1); idle(1'b0);
  endtask

  initial begin
    bit busy_r, quiet_eol;
    int r;
    byte unsigned d;

    m_reset();
    @(negedge i_clk);
    i_rst = 1'b1; i_en = 1'b0;
    @(posedge i_clk); @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0; i_en = 1'b1;
    #1;
    chk("rst_len", o_len, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_state", d_state, 0);
    chk("rst_line", o_line, 0);
    chk("rst_rxr", o_rx_ready, 1);

    // "DUP\n"
    send("D"); send("U"); send("P"); send(8'h0A);
    chk("dup_len", o_len, 4);
    chk("dup_ready", o_ready, 1);
    chk("dup_line", o_line[31:0], {8'h0A, "P", "U", "D"});
    idle(1'b1);
    chk("dup_taken", o_ready, 0);
    idle(1'b1); idle(1'b0);
    chk("dup_cleared", o_len, 0);
    chk("dup_rxr", o_rx_ready, 1);

    // Backspace at empty, then "AB" BS "C\n"
    send(8'h08);
    chk("bs_empty", o_len, 0);
    send("A"); send("B"); send(8'h08); idle(1'b0); idle(1'b0);
    send("C"); send(8'h0A);
    chk("bs_len", o_len, 3);
    chk("bs_line", o_line[23:0], {8'h0A, "C", "A"});
    drain();

    // Overflow: 20 printables then EOL
    for (int i = 0; i < 20; i++) send(8'h61 + i[7:0]);
    send(8'h0A);
    chk("ovf_len", o_len, 15);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_eol", o_line[119:112], 8'h0A);
    chk("ovf_last", o_line[111:104], 8'h6E);
    drain();
    chk("ovf_clear", o_overflow, 0);

    // Strobes during OFFER/DRAIN, reset in DRAIN
    send("X"); send(8'h0A);
    cyc(1'b0, 1'b1, 1'b1, "Q", 1'b0);
    cyc(1'b0, 1'b1, 1'b1, "R", 1'b1);
    cyc(1'b0, 1'b1, 1'b1, "S", 1'b1);
    chk("hold_line", o_line[15:0], {8'h0A, "X"});
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("drain_rst_state", d_state, 0);
    chk("drain_rst_len", o_len, 0);
    chk("drain_rst_ready", o_ready, 0);
    idle(1'b0);

    // Clock enable low
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, "Z", 1'b0);
    chk("en_len", o_len, 0);
    send("K");
    chk("en_resume", o_len, 1);
    send(8'h0A); drain();

`ifdef LINE_CTRL_ECHO_EN
    send("X");
    chk("echo_x", o_tx_data, "X");
    send(8'h08);
    chk("echo_bs1", o_tx_data, 8'h08);
    chk("echo_hold1", o_rx_ready, 0);
    idle(1'b0);
    chk("echo_sp", o_tx_data, 8'h20);
    chk("echo_hold2", o_rx_ready, 0);
    idle(1'b0);
    chk("echo_bs2", o_tx_data, 8'h08);
    chk("echo_free", o_rx_ready, 1);
    send(8'h0A); drain();
`endif

    // Random traffic
    busy_r = 0; quiet_eol = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) quiet_eol = ~quiet_eol;
      if ($urandom_range(0, 5) == 0) busy_r = ~busy_r;
      r = $urandom_range(0, 15);
      if (r < 2 && !quiet_eol)      d = 8'h0A;
      else if (r == 2)              d = 8'h08;
      else if (r == 3)              d = 8'h7F;
      else if (r == 4)              d = 8'h0D;
      else                          d = byte'($urandom_range(8'h20, 8'h7E));
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 1) == 1, d, busy_r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
